// File: rtl/arbiter_4_req_pkg.sv
// arbiter_4_req_pkg: shared state encoding, sizes and index-to-one-hot helper for the 4-requester arbiter
package arbiter_4_req_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  function automatic logic [NREQ-1:0] to_onehot(input logic [ID_W-1:0] id);
    return NREQ'(1) << id;
  endfunction
endpackage

// File: rtl/arbiter_4_req_rot_prio_enc_4.sv
// rot_prio_enc_4: priority encoder whose search starts at start and descends with wrap-around
module rot_prio_enc_4
  import arbiter_4_req_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] id,
  output logic            any
);
  // Walk from the lowest-priority slot up so the highest-priority hit is written last
  always_comb begin
    id = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[start - ID_W'(i)]) id = start - ID_W'(i);
  end
  assign any = |req;
endmodule

// File: rtl/arbiter_4_req.sv
// arbiter_4_req: 4-requester arbiter with fixed or round-robin priority and a bounded hold time
module arbiter_4_req
  import arbiter_4_req_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int HOLD_MAX    = 16,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid,
  output logic            timeout
);
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ID_W-1:0]   last_id, last_n, id_n, win, start;
  logic [NREQ-1:0]   grant_n;
  logic              timeout_n, any, expired, rel;
  assign start = (ROUND_ROBIN != 0) ? last_id - ID_W'(1) : ID_W'(NREQ - 1);
  rot_prio_enc_4 u_enc (.req(req), .start(start), .id(win), .any(any));
  assign expired = cnt == CNT_W'(HOLD_MAX - 1);
  assign rel     = done || !req[grant_id] || expired;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_n    = last_id;
    id_n      = grant_id;
    grant_n   = grant;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (any) begin
        state_n = GRANT;
        id_n    = win;
        grant_n = to_onehot(win);
        last_n  = win;
        cnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
      if (rel) begin
        state_n   = IDLE;
        id_n      = '0;
        grant_n   = '0;
        // A release by the owner wins over an expiry on the same cycle
        timeout_n = expired && !done && req[grant_id];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_id     <= '0;
      grant_id    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last_id     <= last_n;
      grant_id    <= id_n;
      grant       <= grant_n;
      grant_valid <= |grant_n;
      timeout     <= timeout_n;
    end
  end
endmodule

// File: tb/tb_arbiter_4_req.sv
// tb_arbiter_4_req: directed scoreboard bench over fixed, round-robin and short-hold arbiter instances
module tb_arbiter_4_req;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic            done = 1'b0;
  logic [2:0][3:0] g_o;
  logic [2:0][1:0] id_o;
  logic [2:0]      v_o, to_o;
  int              pass = 0;
  int              total = 0;
  typedef struct packed {logic [1:0] k; logic [3:0] g; logic [1:0] id; logic to;} exp_t;
  exp_t  q[$];
  string tq[$];
  always #5 clk = ~clk;
  arbiter_4_req #(.ROUND_ROBIN(0)) u_fix (.clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g_o[0]), .grant_id(id_o[0]), .grant_valid(v_o[0]), .timeout(to_o[0]));
  arbiter_4_req u_rr (.clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g_o[1]), .grant_id(id_o[1]), .grant_valid(v_o[1]), .timeout(to_o[1]));
  arbiter_4_req #(.HOLD_MAX(4)) u_hm (.clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g_o[2]), .grant_id(id_o[2]), .grant_valid(v_o[2]), .timeout(to_o[2]));
  task automatic push(input string t, input int k, input logic [3:0] g, input logic [1:0] id, input logic to);
    q.push_back('{k: 2'(k), g: g, id: id, to: to});
    tq.push_back(t);
  endtask
  task automatic push_idle(input string t);
    for (int k = 0; k < 3; k++) push(t, k, 4'b0000, 2'd0, 1'b0);
  endtask
  // Drive inputs for one cycle, then compare everything expected after that edge
  task automatic tick(input logic [3:0] r, input logic d, input logic rs);
    exp_t  e;
    string t;
    req = r; done = d; rst = rs;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      total++;
      assert ({g_o[e.k], id_o[e.k], v_o[e.k], to_o[e.k]} === {e.g, e.id, |e.g, e.to}) pass++;
      else $error("FAIL %s dut%0d: got grant=%b id=%0d valid=%b timeout=%b, expected grant=%b id=%0d valid=%b timeout=%b",
                  t, e.k, g_o[e.k], id_o[e.k], v_o[e.k], to_o[e.k], e.g, e.id, |e.g, e.to);
    end
  endtask
  function automatic logic [1:0] idx(input logic [3:0] g);
    return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction
  initial begin
    // 1: reset, fixed-priority grant, reset mid-grant
    push_idle("reset");
    tick(4'b0000, 1'b0, 1'b1);
    push("t1_grant", 0, 4'b0100, 2'd2, 1'b0);
    tick(4'b0101, 1'b0, 1'b0);
    push_idle("t1_rst_mid_grant");
    tick(4'b0101, 1'b1, 1'b1);
    // 2: fixed mode, done on 3rd grant cycle
    push("t2_c1", 0, 4'b1000, 2'd3, 1'b0);
    tick(4'b1011, 1'b0, 1'b0);
    push("t2_c2", 0, 4'b1000, 2'd3, 1'b0);
    tick(4'b1011, 1'b0, 1'b0);
    push("t2_c3", 0, 4'b1000, 2'd3, 1'b0);
    tick(4'b1011, 1'b0, 1'b0);
    push("t2_idle", 0, 4'b0000, 2'd0, 1'b0);
    tick(4'b1011, 1'b1, 1'b0);
    push("t2_regrant", 0, 4'b1000, 2'd3, 1'b0);
    tick(4'b1011, 1'b0, 1'b0);
    // 3: round-robin rotation 3,2,1,0,3
    tick(4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      push($sformatf("t3_grant%0d", n), 1, 4'b1000 >> (n % 4), 2'(3 - n % 4), 1'b0);
      tick(4'b1111, 1'b0, 1'b0);
      if (n < 4) begin
        push($sformatf("t3_idle%0d", n), 1, 4'b0000, 2'd0, 1'b0);
        tick(4'b1111, 1'b1, 1'b0);
      end
    end
    // 4: HOLD_MAX=4 timeout, then done on last allowed cycle
    tick(4'b0000, 1'b0, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      push($sformatf("t4_hold%0d", n), 2, 4'b0010, 2'd1, 1'b0);
      tick(4'b0010, 1'b0, 1'b0);
    end
    push("t4_timeout", 2, 4'b0000, 2'd0, 1'b1);
    tick(4'b0010, 1'b0, 1'b0);
    push("t4_regrant", 2, 4'b0010, 2'd1, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    for (int n = 2; n <= 4; n++) begin
      push($sformatf("t4b_hold%0d", n), 2, 4'b0010, 2'd1, 1'b0);
      tick(4'b0010, 1'b0, 1'b0);
    end
    push("t4b_done_no_timeout", 2, 4'b0000, 2'd0, 1'b0);
    tick(4'b0010, 1'b1, 1'b0);
    // 5: owner drops request
    tick(4'b0000, 1'b0, 1'b1);
    push("t5_grant1", 0, 4'b0010, 2'd1, 1'b0);
    tick(4'b0011, 1'b0, 1'b0);
    push("t5_drop", 0, 4'b0000, 2'd0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    push("t5_grant0", 0, 4'b0001, 2'd0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    // 6: quiet after reset, then random invariants
    tick(4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      push_idle($sformatf("t6_quiet%0d", n));
      tick(4'b0000, 1'b0, 1'b0);
    end
    for (int n = 0; n < 300; n++) begin
      tick(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0);
      for (int k = 0; k < 3; k++) begin
        total++;
        assert ($onehot0(g_o[k]) && id_o[k] == idx(g_o[k]) && v_o[k] == |g_o[k] && (!to_o[k] || g_o[k] == 4'b0000)) pass++;
        else $error("FAIL t6_invariant dut%0d: got grant=%b id=%0d valid=%b timeout=%b, expected one-hot-or-zero grant with matching id/valid",
                    k, g_o[k], id_o[k], v_o[k], to_o[k]);
      end
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
